// File: rtl/lc3_rf_dbg_arbiter_if.sv
// Debug host command/response channel of the LC-3 register-file arbiter.
interface lc3_rf_dbg_arbiter_if;
  logic        dbg_cmd_valid;
  logic        dbg_cmd_ready;
  logic        dbg_cmd_op;
  logic [2:0]  dbg_cmd_reg;
  logic [15:0] dbg_cmd_data;
  logic        dbg_rsp_valid;
  logic        dbg_rsp_ready;
  logic [2:0]  dbg_rsp_reg;
  logic [15:0] dbg_rsp_data;
  logic        dbg_rsp_last;

  // Debug host side
  modport master (
    output dbg_cmd_valid, dbg_cmd_op, dbg_cmd_reg, dbg_cmd_data, dbg_rsp_ready,
    input  dbg_cmd_ready, dbg_rsp_valid, dbg_rsp_reg, dbg_rsp_data, dbg_rsp_last
  );

  // Arbiter side
  modport slave (
    input  dbg_cmd_valid, dbg_cmd_op, dbg_cmd_reg, dbg_cmd_data, dbg_rsp_ready,
    output dbg_cmd_ready, dbg_rsp_valid, dbg_rsp_reg, dbg_rsp_data, dbg_rsp_last
  );
endinterface

// File: rtl/lc3_rf_dbg_arbiter.sv
// Shares the LC-3 register file between CPU writeback and a debug host:
// CPU writes always win, debug writes fill idle write slots (with a hold
// request after prolonged blocking), and a dump walks R0..R7 through the
// display read port onto a valid/ready response stream.
module lc3_rf_dbg_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_drmux,
  input  logic [2:0]  cpu_dr,
  input  logic [15:0] cpu_d,
  output logic        cpu_hold,
  input  logic [3:0]  disp_sw,
  lc3_rf_dbg_arbiter_if.slave dbg,
  output logic        rf_we,
  output logic [1:0]  rf_drmux,
  output logic [2:0]  rf_dr,
  output logic [15:0] rf_d,
  output logic [3:0]  rf_dis_sw,
  input  logic [15:0] rf_dis_reg,
  output logic        busy
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [REG_W-1:0] LAST_REG = REG_W'(7);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_WAIT   = 2'd1,
    DUMP_SET  = 2'd2,
    DUMP_SEND = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [REG_W-1:0]    idx, idx_nxt;
  logic [CNT_W-1:0]    starve_cnt, starve_cnt_nxt;
  logic [REG_W-1:0]    wr_reg, wr_reg_nxt;
  logic [DATA_W-1:0]   wr_data, wr_data_nxt;
  logic                rsp_valid, rsp_valid_nxt;
  logic [REG_W-1:0]    rsp_reg, rsp_reg_nxt;
  logic [DATA_W-1:0]   rsp_data, rsp_data_nxt;
  logic                rsp_last, rsp_last_nxt;
  logic                cmd_ready;

  assign dbg.dbg_cmd_ready = cmd_ready;
  assign dbg.dbg_rsp_valid = rsp_valid;
  assign dbg.dbg_rsp_reg   = rsp_reg;
  assign dbg.dbg_rsp_data  = rsp_data;
  assign dbg.dbg_rsp_last  = rsp_last;
  assign busy              = (state != IDLE) && !rst;

  // State and datapath registers; reset drops any pending debug write
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      starve_cnt <= '0;
      wr_reg     <= '0;
      wr_data    <= '0;
      rsp_valid  <= 1'b0;
      rsp_reg    <= '0;
      rsp_data   <= '0;
      rsp_last   <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      starve_cnt <= starve_cnt_nxt;
      wr_reg     <= wr_reg_nxt;
      wr_data    <= wr_data_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_reg    <= rsp_reg_nxt;
      rsp_data   <= rsp_data_nxt;
      rsp_last   <= rsp_last_nxt;
    end
  end

  // Next-state logic plus write-port / display-port steering
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    starve_cnt_nxt = starve_cnt;
    wr_reg_nxt     = wr_reg;
    wr_data_nxt    = wr_data;
    rsp_valid_nxt  = rsp_valid;
    rsp_reg_nxt    = rsp_reg;
    rsp_data_nxt   = rsp_data;
    rsp_last_nxt   = rsp_last;
    rf_we          = cpu_we;
    rf_drmux       = cpu_drmux;
    rf_dr          = cpu_dr;
    rf_d           = cpu_d;
    rf_dis_sw      = disp_sw;
    cpu_hold       = 1'b0;
    cmd_ready      = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready = !rst;
        if (dbg.dbg_cmd_valid && !rst) begin
          if (dbg.dbg_cmd_op) begin
            idx_nxt   = '0;
            state_nxt = DUMP_SET;
          end else begin
            wr_reg_nxt  = dbg.dbg_cmd_reg;
            wr_data_nxt = dbg.dbg_cmd_data;
            state_nxt   = WR_WAIT;
          end
        end
      end

      WR_WAIT: begin
        cpu_hold = (starve_cnt == CNT_MAX);
        if (cpu_we) begin
          // CPU keeps the port even while hold is requested
          if (starve_cnt != CNT_MAX) begin
            starve_cnt_nxt = CNT_W'(starve_cnt + CNT_W'(1));
          end
        end else begin
          rf_we          = 1'b1;
          rf_drmux       = 2'b00;
          rf_dr          = wr_reg;
          rf_d           = wr_data;
          starve_cnt_nxt = '0;
          state_nxt      = IDLE;
        end
      end

      DUMP_SET: begin
        // Capture happens before any same-cycle CPU write lands
        rf_dis_sw     = {1'b0, idx};
        rsp_data_nxt  = rf_dis_reg;
        rsp_reg_nxt   = idx;
        rsp_last_nxt  = (idx == LAST_REG);
        rsp_valid_nxt = 1'b1;
        state_nxt     = DUMP_SEND;
      end

      DUMP_SEND: begin
        rf_dis_sw = {1'b0, idx};
        if (dbg.dbg_rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          if (idx == LAST_REG) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt   = REG_W'(idx + REG_W'(1));
            state_nxt = DUMP_SET;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    // While in reset the file belongs to the CPU and the board switches
    if (rst) begin
      rf_we     = cpu_we;
      rf_drmux  = cpu_drmux;
      rf_dr     = cpu_dr;
      rf_d      = cpu_d;
      rf_dis_sw = disp_sw;
      cpu_hold  = 1'b0;
    end
  end

endmodule

// File: tb/tb_lc3_rf_dbg_arbiter.sv
// Directed bench for lc3_rf_dbg_arbiter with a simple register-file model,
// per-cycle rule checks and scoreboards for debug writes and dump words.
module tb_lc3_rf_dbg_arbiter;

  localparam int unsigned STARVE_LIMIT = 4;

  typedef struct packed {
    logic [2:0]  r;
    logic [15:0] d;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we;
  logic [1:0]  cpu_drmux;
  logic [2:0]  cpu_dr;
  logic [15:0] cpu_d;
  logic        cpu_hold;
  logic [3:0]  disp_sw;
  logic        rf_we;
  logic [1:0]  rf_drmux;
  logic [2:0]  rf_dr;
  logic [15:0] rf_d;
  logic [3:0]  rf_dis_sw;
  logic [15:0] rf_dis_reg;
  logic        busy;

  lc3_rf_dbg_arbiter_if dbg_if();

  lc3_rf_dbg_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_we     (cpu_we),
    .cpu_drmux  (cpu_drmux),
    .cpu_dr     (cpu_dr),
    .cpu_d      (cpu_d),
    .cpu_hold   (cpu_hold),
    .disp_sw    (disp_sw),
    .dbg        (dbg_if),
    .rf_we      (rf_we),
    .rf_drmux   (rf_drmux),
    .rf_dr      (rf_dr),
    .rf_d       (rf_d),
    .rf_dis_sw  (rf_dis_sw),
    .rf_dis_reg (rf_dis_reg),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // LC-3 register file: DR mux 00 = IR[11:9], 01 = R7, 10 = R6
  logic [15:0] regs [8];
  logic [2:0]  wr_dest;
  always_comb wr_dest = (rf_drmux == 2'b01) ? 3'd7 : (rf_drmux == 2'b10) ? 3'd6 : rf_dr;
  always @(posedge clk) if (rf_we) regs[wr_dest] <= rf_d;
  assign rf_dis_reg = regs[rf_dis_sw[2:0]];

  int n_chk  = 0;
  int n_fail = 0;
  word_t exp_wr[$];
  word_t exp_rsp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic issue_cmd(input logic op, input logic [2:0] r, input logic [15:0] d);
    dbg_if.dbg_cmd_valid = 1'b1;
    dbg_if.dbg_cmd_op    = op;
    dbg_if.dbg_cmd_reg   = r;
    dbg_if.dbg_cmd_data  = d;
    if (!op) exp_wr.push_back('{r: r, d: d});
    settle();
    chk("cmd_ready_on_issue", 32'(dbg_if.dbg_cmd_ready), 32'd1);
    tick();
    dbg_if.dbg_cmd_valid = 1'b0;
  endtask

  task automatic push_dump(input logic [15:0] r4_val);
    for (int i = 0; i < 8; i++) begin
      exp_rsp.push_back('{r: 3'(i), d: (i == 4) ? r4_val : 16'(16'h1000 + i)});
    end
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      settle();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  // Per-cycle rules: CPU priority, idle pass-through, response stability, scoreboards
  logic        prev_stall = 1'b0;
  logic [2:0]  prev_reg;
  logic [15:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    word_t w;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (cpu_we) begin
        chk("cpu_priority", 32'({rf_we, rf_drmux, rf_dr, rf_d}), 32'({1'b1, cpu_drmux, cpu_dr, cpu_d}));
      end else if (rf_we) begin
        chk("dbg_write_expected", 32'(exp_wr.size() > 0), 32'd1);
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          chk("dbg_write_port", 32'({rf_drmux, rf_dr, rf_d}), 32'({2'b00, w.r, w.d}));
        end
      end
      if (!busy) begin
        chk("idle_passthrough", 32'({rf_we, rf_drmux, rf_dr, rf_d, rf_dis_sw}),
            32'({cpu_we, cpu_drmux, cpu_dr, cpu_d, disp_sw}));
      end
      chk("ready_vs_busy", 32'(dbg_if.dbg_cmd_ready), 32'(!busy));
      if (cpu_hold) chk("hold_only_when_busy", 32'(busy), 32'd1);
      if (prev_stall) begin
        chk("rsp_stable", 32'({dbg_if.dbg_rsp_valid, dbg_if.dbg_rsp_reg, dbg_if.dbg_rsp_data, dbg_if.dbg_rsp_last}),
            32'({1'b1, prev_reg, prev_data, prev_last}));
      end
      if (dbg_if.dbg_rsp_valid && dbg_if.dbg_rsp_ready) begin
        chk("rsp_expected", 32'(exp_rsp.size() > 0), 32'd1);
        if (exp_rsp.size() > 0) begin
          w = exp_rsp.pop_front();
          chk("rsp_word", 32'({dbg_if.dbg_rsp_reg, dbg_if.dbg_rsp_data, dbg_if.dbg_rsp_last}),
              32'({w.r, w.d, (w.r == 3'd7)}));
        end
      end
      prev_stall = dbg_if.dbg_rsp_valid && !dbg_if.dbg_rsp_ready;
      prev_reg   = dbg_if.dbg_rsp_reg;
      prev_data  = dbg_if.dbg_rsp_data;
      prev_last  = dbg_if.dbg_rsp_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    logic found;
    rst = 1'b1;
    cpu_we = 1'b1; cpu_drmux = 2'b00; cpu_dr = 3'd2; cpu_d = 16'h0222;
    disp_sw = 4'h5;
    dbg_if.dbg_cmd_valid = 1'b0; dbg_if.dbg_cmd_op = 1'b0;
    dbg_if.dbg_cmd_reg = 3'd0; dbg_if.dbg_cmd_data = 16'h0;
    dbg_if.dbg_rsp_ready = 1'b1;

    // Reset behaviour
    tick(); settle();
    chk("rst_ready", 32'(dbg_if.dbg_cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_rf_pass", 32'({rf_we, rf_dr, rf_d}), 32'({1'b1, 3'd2, 16'h0222}));
    chk("rst_dis_sw", 32'(rf_dis_sw), 32'h5);
    tick();
    rst = 1'b0; cpu_we = 1'b0;
    settle();
    chk("post_rst_ready", 32'(dbg_if.dbg_cmd_ready), 32'd1);
    chk("post_rst_rsp", 32'({dbg_if.dbg_rsp_valid, dbg_if.dbg_rsp_reg, dbg_if.dbg_rsp_data, dbg_if.dbg_rsp_last}), 32'd0);

    // Debug write with CPU idle
    tick();
    issue_cmd(1'b0, 3'd3, 16'hBEEF);
    settle();
    chk("t1_rf_port", 32'({rf_we, rf_drmux, rf_dr, rf_d}), 32'({1'b1, 2'b00, 3'd3, 16'hBEEF}));
    chk("t1_busy", 32'(busy), 32'd1);
    tick(); settle();
    chk("t1_ready_back", 32'(dbg_if.dbg_cmd_ready), 32'd1);
    chk("t1_r3", 32'(regs[3]), 32'hBEEF);

    // Debug write while the CPU writes every cycle
    tick();
    cpu_we = 1'b1; cpu_drmux = 2'b00; cpu_dr = 3'd1; cpu_d = 16'h0055;
    issue_cmd(1'b0, 3'd5, 16'h1234);
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk("t2_hold_low", 32'(cpu_hold), 32'd0);
      tick();
    end
    settle();
    chk("t2_hold_high", 32'(cpu_hold), 32'd1);
    chk("t2_cpu_still_wins", 32'(rf_d), 32'h0055);
    cpu_we = 1'b0;
    #1;
    chk("t2_dbg_slot", 32'({rf_we, rf_drmux, rf_dr, rf_d}), 32'({1'b1, 2'b00, 3'd5, 16'h1234}));
    tick(); settle();
    chk("t2_hold_drop", 32'(cpu_hold), 32'd0);
    chk("t2_ready", 32'(dbg_if.dbg_cmd_ready), 32'd1);
    chk("t2_r5", 32'(regs[5]), 32'h1234);
    chk("t2_r1", 32'(regs[1]), 32'h0055);

    // Preload R0..R7 through the CPU path, then dump with ready tied high
    tick();
    for (int i = 0; i < 8; i++) begin
      cpu_we = 1'b1; cpu_drmux = 2'b00; cpu_dr = 3'(i); cpu_d = 16'(16'h1000 + i);
      tick();
    end
    cpu_we = 1'b0;
    push_dump(16'h1004);
    issue_cmd(1'b1, 3'd0, 16'h0);
    settle();
    chk("t3_not_valid_t1", 32'(dbg_if.dbg_rsp_valid), 32'd0);
    chk("t3_dis_sw_r0", 32'(rf_dis_sw), 32'h0);
    tick(); settle();
    chk("t3_r0_word", 32'({dbg_if.dbg_rsp_valid, dbg_if.dbg_rsp_reg, dbg_if.dbg_rsp_data, dbg_if.dbg_rsp_last}),
        32'({1'b1, 3'd0, 16'h1000, 1'b0}));
    cyc = 2;
    while (!(dbg_if.dbg_rsp_valid && dbg_if.dbg_rsp_last) && cyc < 40) begin
      tick(); settle(); cyc++;
    end
    chk("t3_last_cycle", 32'(cyc), 32'd16);
    chk("t3_r7_word", 32'({dbg_if.dbg_rsp_reg, dbg_if.dbg_rsp_data}), 32'({3'd7, 16'h1007}));
    tick(); settle();
    chk("t3_idle_after", 32'({busy, dbg_if.dbg_cmd_ready, dbg_if.dbg_rsp_valid}), 32'b010);
    chk("t3_drained", 32'(exp_rsp.size()), 32'd0);

    // Dump with back-pressure on the R2 word
    tick();
    push_dump(16'h1004);
    issue_cmd(1'b1, 3'd0, 16'h0);
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      settle();
      if (dbg_if.dbg_rsp_valid && dbg_if.dbg_rsp_reg == 3'd2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("t4_r2_seen", 32'(found), 32'd1);
    dbg_if.dbg_rsp_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(); settle();
      chk("t4_stalled_word", 32'({dbg_if.dbg_rsp_valid, dbg_if.dbg_rsp_reg, dbg_if.dbg_rsp_data}),
          32'({1'b1, 3'd2, 16'h1002}));
    end
    tick();
    dbg_if.dbg_rsp_ready = 1'b1;
    wait_idle("t4_finish");
    chk("t4_drained", 32'(exp_rsp.size()), 32'd0);

    // CPU write to R4 in R4's capture cycle
    tick();
    cpu_we = 1'b1; cpu_drmux = 2'b00; cpu_dr = 3'd4; cpu_d = 16'h0004;
    tick();
    cpu_we = 1'b0;
    push_dump(16'h0004);
    issue_cmd(1'b1, 3'd0, 16'h0);
    repeat (8) tick();
    cpu_we = 1'b1; cpu_dr = 3'd4; cpu_d = 16'hAAAA;
    settle();
    chk("t5_dis_sw_r4", 32'(rf_dis_sw), 32'h4);
    chk("t5_capture_cycle", 32'({busy, dbg_if.dbg_rsp_valid}), 32'b10);
    tick();
    cpu_we = 1'b0;
    settle();
    chk("t5_r4_word", 32'({dbg_if.dbg_rsp_valid, dbg_if.dbg_rsp_reg, dbg_if.dbg_rsp_data}),
        32'({1'b1, 3'd4, 16'h0004}));
    chk("t5_r4_file", 32'(regs[4]), 32'hAAAA);
    tick();
    wait_idle("t5_finish");
    chk("t5_drained", 32'(exp_rsp.size()), 32'd0);
    disp_sw = 4'h4;
    #1;
    chk("t5_display_r4", 32'({rf_dis_sw, rf_dis_reg}), 32'({4'h4, 16'hAAAA}));

    // Reset while a starved debug write is pending
    tick();
    disp_sw = 4'h9;
    cpu_we = 1'b1; cpu_drmux = 2'b00; cpu_dr = 3'd6; cpu_d = 16'h0666;
    issue_cmd(1'b0, 3'd2, 16'hDEAD);
    repeat (3) tick();
    tick(); settle();
    chk("t6_hold", 32'(cpu_hold), 32'd1);
    tick(); settle();
    chk("t6_hold_saturated", 32'(cpu_hold), 32'd1);
    chk("t6_cpu_wins", 32'({rf_we, rf_dr, rf_d}), 32'({1'b1, 3'd6, 16'h0666}));
    tick();
    rst = 1'b1; cpu_we = 1'b0;
    exp_wr.delete();
    settle();
    chk("t6_rst_outputs", 32'({cpu_hold, busy, rf_we, dbg_if.dbg_cmd_ready}), 32'b0000);
    chk("t6_rst_dis_sw", 32'(rf_dis_sw), 32'h9);
    tick();
    rst = 1'b0;
    settle();
    chk("t6_after_rst", 32'({busy, dbg_if.dbg_cmd_ready, rf_we}), 32'b010);
    repeat (3) begin tick(); settle(); end
    chk("t6_r2_untouched", 32'(regs[2]), 32'h1002);
    chk("t6_r6_cpu", 32'(regs[6]), 32'h0666);

    // Reset while a dump word is stalled
    tick();
    dbg_if.dbg_rsp_ready = 1'b1;
    push_dump(16'hAAAA);
    issue_cmd(1'b1, 3'd0, 16'h0);
    tick(); settle();
    chk("t7_r0", 32'({dbg_if.dbg_rsp_valid, dbg_if.dbg_rsp_data}), 32'({1'b1, 16'h1000}));
    tick();
    tick();
    dbg_if.dbg_rsp_ready = 1'b0;
    settle();
    chk("t7_r1_stalled", 32'({dbg_if.dbg_rsp_valid, dbg_if.dbg_rsp_reg, dbg_if.dbg_rsp_data}),
        32'({1'b1, 3'd1, 16'h1001}));
    tick();
    rst = 1'b1; disp_sw = 4'hA;
    exp_rsp.delete();
    settle();
    chk("t7_rst_outputs", 32'({busy, dbg_if.dbg_cmd_ready, rf_dis_sw}), 32'({1'b0, 1'b0, 4'hA}));
    tick();
    rst = 1'b0; dbg_if.dbg_rsp_ready = 1'b1;
    settle();
    chk("t7_rsp_cleared", 32'({dbg_if.dbg_rsp_valid, dbg_if.dbg_rsp_reg, dbg_if.dbg_rsp_data, dbg_if.dbg_rsp_last}), 32'd0);
    chk("t7_idle", 32'({dbg_if.dbg_cmd_ready, rf_dis_sw}), 32'({1'b1, 4'hA}));
    repeat (3) begin tick(); settle(); end
    chk("t7_no_valid", 32'(dbg_if.dbg_rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
